t08_imem_responder: RTL and testbench

//  Instruction-memory side of the fetch interface. Answers program-counter

---
 rtl/t08_imem_responder.sv | 189 ++++++++++++++++++
 tb/tb_t08_imem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/t08_imem_responder.sv
// t08_imem_responder
//   Instruction-memory side of the fetch interface. Answers program-counter
//   requests with a 32-bit instruction word, using a one-entry buffer of the
//   last fetched word and a single-outstanding read on the shared memory bus.
//   Stall is driven back to fetch while a request is not yet served.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   i_pc           requested instruction byte address
//   i_pc_req       fetch requests the word at i_pc this cycle
//   i_flush        jump/branch taken; abandon in-flight request
//   o_instr        returned instruction word (holds when not valid)
//   o_instr_valid  1-cycle pulse, o_instr valid
//   o_stall        fetch must hold pc (combinational)
//   o_fault        1-cycle pulse: misaligned pc or bus timeout
//   o_bus_addr     read address to memory bus
//   o_bus_read     read strobe, held until i_bus_ack
//   i_bus_rdata    read data, valid with i_bus_ack
//   i_bus_ack      read complete
module t08_imem_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_pc_req,
    input  logic        i_flush,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic        o_stall,
    output logic        o_fault,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_read,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    // One spare bit so the count can step past TIMEOUT-1 when a flush
    // moves BUSY into DRAIN on the final cycle.
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic            r_fault;
    logic [31:0]     r_bus_addr;
    logic            r_bus_read;
    logic            r_buf_valid;
    logic [31:0]     r_buf_addr;
    logic [31:0]     r_buf_data;
    logic [CW-1:0]   r_count;

    state_t          w_state_nxt;
    logic [31:0]     w_instr_nxt;
    logic            w_instr_valid_nxt;
    logic            w_fault_nxt;
    logic [31:0]     w_bus_addr_nxt;
    logic            w_bus_read_nxt;
    logic            w_buf_valid_nxt;
    logic [31:0]     w_buf_addr_nxt;
    logic [31:0]     w_buf_data_nxt;
    logic [CW-1:0]   w_count_nxt;

    logic            w_hit;
    logic            w_misaligned;

    assign w_hit        = r_buf_valid && (r_buf_addr == i_pc);
    assign w_misaligned = (i_pc[1:0] != 2'b00);

    // Requests answered in one cycle (hit or misaligned) never stall.
    assign o_stall = (r_state != IDLE) || (i_pc_req && !(w_hit || w_misaligned));

    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_fault       = r_fault;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_read    = r_bus_read;

    always_comb begin
        w_state_nxt       = r_state;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = 1'b0;
        w_fault_nxt       = 1'b0;
        w_bus_addr_nxt    = r_bus_addr;
        w_bus_read_nxt    = r_bus_read;
        w_buf_valid_nxt   = r_buf_valid;
        w_buf_addr_nxt    = r_buf_addr;
        w_buf_data_nxt    = r_buf_data;
        w_count_nxt       = r_count;

        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (i_pc_req) begin
                    if (w_misaligned) begin
                        w_fault_nxt = 1'b1;
                    end else if (w_hit) begin
                        // A flush in the same cycle cancels the hit pulse.
                        if (!i_flush) begin
                            w_instr_nxt       = r_buf_data;
                            w_instr_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_bus_addr_nxt = i_pc;
                        w_bus_read_nxt = 1'b1;
                        w_state_nxt    = BUSY;
                    end
                end
            end

            BUSY: begin
                w_count_nxt = r_count + 1'b1;
                if (i_bus_ack) begin
                    w_bus_read_nxt = 1'b0;
                    w_count_nxt    = '0;
                    w_state_nxt    = IDLE;
                    if (!i_flush) begin
                        w_buf_valid_nxt   = 1'b1;
                        w_buf_addr_nxt    = r_bus_addr;
                        w_buf_data_nxt    = i_bus_rdata;
                        w_instr_nxt       = i_bus_rdata;
                        w_instr_valid_nxt = 1'b1;
                    end
                end else if (i_flush) begin
                    // The bus cannot abort; keep the strobe up and swallow the reply.
                    w_state_nxt = DRAIN;
                end else if (r_count == LAST) begin
                    w_instr_nxt       = NOP_WORD;
                    w_instr_valid_nxt = 1'b1;
                    w_fault_nxt       = 1'b1;
                    w_bus_read_nxt    = 1'b0;
                    w_count_nxt       = '0;
                    w_state_nxt       = IDLE;
                end
            end

            DRAIN: begin
                w_count_nxt = r_count + 1'b1;
                if (i_bus_ack || (r_count >= LAST)) begin
                    w_bus_read_nxt = 1'b0;
                    w_count_nxt    = '0;
                    w_state_nxt    = IDLE;
                end
            end

            default: begin
                w_bus_read_nxt = 1'b0;
                w_count_nxt    = '0;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_read    <= 1'b0;
            r_buf_valid   <= 1'b0;
            r_buf_addr    <= '0;
            r_buf_data    <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_bus_addr    <= w_bus_addr_nxt;
            r_bus_read    <= w_bus_read_nxt;
            r_buf_valid   <= w_buf_valid_nxt;
            r_buf_addr    <= w_buf_addr_nxt;
            r_buf_data    <= w_buf_data_nxt;
            r_count       <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_t08_imem_responder.sv
// tb_t08_imem_responder
//   Directed bench for t08_imem_responder: miss, hit, misaligned, timeout,
//   flush mid-read, flush with ack, flush of a hit, reset mid-read.
module tb_t08_imem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_req;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        fault;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int unsigned n_checks;
    int unsigned n_fails;

    t08_imem_responder #(
        .TIMEOUT  (16),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc          (pc),
        .i_pc_req      (pc_req),
        .i_flush       (flush),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_stall       (stall),
        .o_fault       (fault),
        .o_bus_addr    (bus_addr),
        .o_bus_read    (bus_read),
        .i_bus_rdata   (bus_rdata),
        .i_bus_ack     (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs changed afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        pc        = '0;
        pc_req    = 1'b0;
        flush     = 1'b0;
        bus_rdata = '0;
        bus_ack   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_instr",  instr,       32'h0);
        check("rst_valid",  instr_valid, 32'h0);
        check("rst_stall",  stall,       32'h0);
        check("rst_fault",  fault,       32'h0);
        check("rst_baddr",  bus_addr,    32'h0);
        check("rst_bread",  bus_read,    32'h0);
        rst = 1'b0;

        // 1. Miss at 0x10, ack sampled on the third edge after bus_read rises
        pc = 32'h10; pc_req = 1'b1; #1;
        check("miss_stall_req", stall, 32'h1);
        tick();
        pc_req = 1'b0;
        check("miss_bread", bus_read, 32'h1);
        check("miss_baddr", bus_addr, 32'h10);
        check("miss_stall_busy", stall, 32'h1);
        tick();
        tick();
        check("miss_valid_early", instr_valid, 32'h0);
        check("miss_stall_wait", stall, 32'h1);
        bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        check("miss_valid", instr_valid, 32'h1);
        check("miss_instr", instr, 32'h0050_0093);
        check("miss_bread_off", bus_read, 32'h0);
        check("miss_stall_off", stall, 32'h0);
        tick();
        check("miss_valid_pulse", instr_valid, 32'h0);
        check("miss_instr_hold", instr, 32'h0050_0093);

        // 2. Hit at 0x10
        pc = 32'h10; pc_req = 1'b1; #1;
        check("hit_stall", stall, 32'h0);
        tick();
        pc_req = 1'b0;
        check("hit_valid", instr_valid, 32'h1);
        check("hit_instr", instr, 32'h0050_0093);
        check("hit_bread", bus_read, 32'h0);
        tick();
        check("hit_valid_pulse", instr_valid, 32'h0);

        // 3. Misaligned 0x12
        pc = 32'h12; pc_req = 1'b1; #1;
        check("mis_stall", stall, 32'h0);
        tick();
        pc_req = 1'b0;
        check("mis_fault", fault, 32'h1);
        check("mis_valid", instr_valid, 32'h0);
        check("mis_bread", bus_read, 32'h0);
        tick();
        check("mis_fault_pulse", fault, 32'h0);

        // 4. Timeout at 0x20: fault on the 16th edge after bus_read rises
        pc = 32'h20; pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("to_bread", bus_read, 32'h1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_nofault", fault, 32'h0);
        end
        check("to_bread_held", bus_read, 32'h1);
        tick();
        check("to_fault", fault, 32'h1);
        check("to_valid", instr_valid, 32'h1);
        check("to_instr", instr, 32'h0000_0013);
        check("to_bread_off", bus_read, 32'h0);
        tick();
        check("to_fault_pulse", fault, 32'h0);
        // buffer must still hold 0x10
        pc = 32'h10; pc_req = 1'b1; #1;
        check("to_buf_kept_stall", stall, 32'h0);
        tick();
        pc_req = 1'b0;
        check("to_buf_kept_instr", instr, 32'h0050_0093);

        // 5. Flush mid-read at 0x30
        pc = 32'h30; pc_req = 1'b1;
        tick();
        pc_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_bread_held", bus_read, 32'h1);
        check("fl_stall", stall, 32'h1);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        check("fl_valid", instr_valid, 32'h0);
        check("fl_fault", fault, 32'h0);
        check("fl_bread_off", bus_read, 32'h0);
        check("fl_instr_hold", instr, 32'h0050_0093);
        tick();
        pc = 32'h30; pc_req = 1'b1; #1;
        check("fl_remiss_stall", stall, 32'h1);
        tick();
        pc_req = 1'b0;
        check("fl_remiss_bread", bus_read, 32'h1);
        check("fl_remiss_baddr", bus_addr, 32'h30);
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        check("fl_refill_valid", instr_valid, 32'h1);
        check("fl_refill_instr", instr, 32'h1111_1111);

        // Flush in IDLE cancels a hit
        pc = 32'h30; pc_req = 1'b1; flush = 1'b1;
        tick();
        pc_req = 1'b0; flush = 1'b0;
        check("flhit_valid", instr_valid, 32'h0);

        // Flush and ack on the same edge: data discarded, buffer untouched
        pc = 32'h40; pc_req = 1'b1;
        tick();
        pc_req = 1'b0; flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
        tick();
        flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        check("flack_valid", instr_valid, 32'h0);
        check("flack_bread", bus_read, 32'h0);
        pc = 32'h40; pc_req = 1'b1; #1;
        check("flack_miss", stall, 32'h1);
        pc = 32'h30; #1;
        check("flack_buf_kept", stall, 32'h0);
        pc_req = 1'b0;
        tick();

        // 6. Reset mid-read
        pc = 32'h50; pc_req = 1'b1;
        tick();
        pc_req = 1'b0;
        check("rm_bread", bus_read, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_bread_off", bus_read, 32'h0);
        check("rm_stall", stall, 32'h0);
        check("rm_baddr", bus_addr, 32'h0);
        check("rm_instr", instr, 32'h0);
        pc = 32'h30; pc_req = 1'b1; #1;
        check("rm_buf_inval", stall, 32'h1);
        tick();
        pc_req = 1'b0;
        check("rm_remiss_bread", bus_read, 32'h1);
        check("rm_remiss_baddr", bus_addr, 32'h30);
        bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
        tick();
        bus_ack = 1'b0;
        check("rm_refill_instr", instr, 32'h3333_3333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
